// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch PC unit and its branch target buffer.
package pc_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: flop storage, combinational lookup,
// synchronous update with 2-bit saturating direction counters.
module pc_btb
    import pc_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic             valid      [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_mem    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_mem [BTB_ENTRIES];
    ctr_t             ctr_mem    [BTB_ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    // Instructions are word-aligned, so the low two PC bits never select an entry.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    always_comb begin
        look_idx    = lookup_pc[IDX_W+1:2];
        look_tag    = lookup_pc[XLEN-1:IDX_W+2];
        look_hit    = valid[look_idx] && (tag_mem[look_idx] == look_tag);
        pred_taken  = look_hit && ctr_mem[look_idx][1];
        pred_target = look_hit ? target_mem[look_idx] : '0;
    end

    always_comb begin
        upd_idx = upd_pc[IDX_W+1:2];
        upd_tag = upd_pc[XLEN-1:IDX_W+2];
        upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                ctr_mem[i] <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_mem[upd_idx]    <= (ctr_mem[upd_idx] == CTR_ST) ? CTR_ST
                                                                        : ctr_mem[upd_idx] + 2'd1;
                    target_mem[upd_idx] <= upd_target;
                end else begin
                    ctr_mem[upd_idx]    <= (ctr_mem[upd_idx] == CTR_SNT) ? CTR_SNT
                                                                         : ctr_mem[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                valid[upd_idx]      <= 1'b1;
                tag_mem[upd_idx]    <= upd_tag;
                target_mem[upd_idx] <= upd_target;
                ctr_mem[upd_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-based prediction, stall hold and EX redirect/flush.
module pc_predict_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            flush
);

    logic [XLEN-1:0] pc_next;

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    assign flush = redirect_valid;

    // Redirect wins over stall: a resolved mispredict must never be lost to a hazard hold.
    always_comb begin
        pc_next = pc + XLEN'(PC_STEP);
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (stall) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit with hand-computed expected PCs and predictions.
module tb_pc_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;

    logic        tie0 = 1'b0;
    logic [31:0] tie0_w = '0;
    logic [31:0] rv_pc;
    logic        rv_pred_taken;
    logic [31:0] rv_pred_target;
    logic        rv_flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_predict_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .BTB_ENTRIES  (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .pc              (pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .flush           (flush)
    );

    pc_predict_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'hFFFF_FFF8),
        .BTB_ENTRIES  (16)
    ) dut_rv (
        .clk             (clk),
        .rst             (rst),
        .stall           (tie0),
        .redirect_valid  (tie0),
        .redirect_target (tie0_w),
        .upd_valid       (tie0),
        .upd_pc          (tie0_w),
        .upd_taken       (tie0),
        .upd_target      (tie0_w),
        .pc              (rv_pc),
        .pred_taken      (rv_pred_taken),
        .pred_target     (rv_pred_target),
        .flush           (rv_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        tick; tick;
        rst = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_pred", {31'b0, pred_taken}, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rv_pc0", rv_pc, 32'hFFFF_FFF8);
        check("rv_pred", {31'b0, rv_pred_taken}, 32'h0);

        tick; check("run_pc4", pc, 32'h4);   check("rv_pc1", rv_pc, 32'hFFFF_FFFC);
        tick; check("run_pc8", pc, 32'h8);   check("rv_wrap", rv_pc, 32'h0);
        tick; check("run_pcC", pc, 32'hC);   check("run_pred", {31'b0, pred_taken}, 32'h0);

        // Allocate 0x10 -> 0x40 while fetching 0xC
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h40;
        tick; upd_valid = 1'b0; #1;
        check("alloc_pc", pc, 32'h10);
        check("alloc_pred", {31'b0, pred_taken}, 32'h1);
        check("alloc_tgt", pred_target, 32'h40);
        tick; check("alloc_jump", pc, 32'h40);

        // Three not-taken updates: 10 -> 01 -> 00 -> 00
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0;
        tick; tick; tick;
        upd_valid = 1'b0;
        check("train_seq", pc, 32'h4C);
        redirect_valid = 1'b1; redirect_target = 32'h10; #1;
        check("redir_flush", {31'b0, flush}, 32'h1);
        tick; redirect_valid = 1'b0; #1;
        check("nt_pc", pc, 32'h10);
        check("nt_pred", {31'b0, pred_taken}, 32'h0);
        check("nt_hit_tgt", pred_target, 32'h40);
        tick; check("nt_fall", pc, 32'h14);

        // One taken update from a saturated 00 gives 01: still not-taken
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h40;
        redirect_valid = 1'b1; redirect_target = 32'h10;
        tick; upd_valid = 1'b0; redirect_valid = 1'b0; #1;
        check("sat_pc", pc, 32'h10);
        check("sat_pred", {31'b0, pred_taken}, 32'h0);

        // Same-cycle update at the looked-up index: lookup sees old counter
        upd_valid = 1'b1; #1;
        check("nobyp_pred", {31'b0, pred_taken}, 32'h0);
        tick; upd_valid = 1'b0; #1;
        check("nobyp_pc", pc, 32'h14);
        redirect_valid = 1'b1; redirect_target = 32'h10;
        tick; redirect_valid = 1'b0; #1;
        check("wt_pred", {31'b0, pred_taken}, 32'h1);
        tick; check("wt_jump", pc, 32'h40);

        // Stall holds, redirect overrides stall
        redirect_valid = 1'b1; redirect_target = 32'h8;
        tick; redirect_valid = 1'b0; stall = 1'b1; #1;
        check("stall_pc0", pc, 32'h8);
        tick; check("stall_pc1", pc, 32'h8);
        tick; check("stall_pc2", pc, 32'h8);
        redirect_valid = 1'b1; redirect_target = 32'h100; #1;
        check("stall_flush", {31'b0, flush}, 32'h1);
        tick; redirect_valid = 1'b0; stall = 1'b0; #1;
        check("stall_redir", pc, 32'h100);
        check("flush_low", {31'b0, flush}, 32'h0);

        // Aliasing: 0x50 evicts 0x10 at idx 4
        upd_valid = 1'b1; upd_pc = 32'h50; upd_taken = 1'b1; upd_target = 32'h80;
        tick; upd_valid = 1'b0;
        check("alias_seq", pc, 32'h104);
        redirect_valid = 1'b1; redirect_target = 32'h10;
        tick; redirect_valid = 1'b0; #1;
        check("alias_miss", {31'b0, pred_taken}, 32'h0);
        check("alias_tgt0", pred_target, 32'h0);
        tick; check("alias_fall", pc, 32'h14);
        redirect_valid = 1'b1; redirect_target = 32'h50;
        tick; redirect_valid = 1'b0; #1;
        check("alias_hit", {31'b0, pred_taken}, 32'h1);
        check("alias_htgt", pred_target, 32'h80);
        tick; check("alias_jump", pc, 32'h80);

        // Misaligned redirect passes through unchanged
        redirect_valid = 1'b1; redirect_target = 32'h103;
        tick; redirect_valid = 1'b0; #1;
        check("mis_pc", pc, 32'h103);
        tick; check("mis_inc", pc, 32'h107);

        // Reset dominates a simultaneous taken update
        rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h0; upd_taken = 1'b1; upd_target = 32'h200;
        tick; rst = 1'b0; upd_valid = 1'b0; #1;
        check("rstupd_pc", pc, 32'h0);
        check("rstupd_pred", {31'b0, pred_taken}, 32'h0);
        tick; check("rstupd_run", pc, 32'h4);
        redirect_valid = 1'b1; redirect_target = 32'h50;
        tick; redirect_valid = 1'b0; #1;
        check("rst_clr_btb", {31'b0, pred_taken}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Parametrised next-generation program-counter unit for the 5-stage pipeline.
- Generates the fetch PC and supports stall/hold and resolved-branch redirect with flush.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and jumps are predicted at fetch.
- Sits in IF; the EX stage reports resolution back.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2.
- IDX_W, $clog2(BTB_ENTRIES), index width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold the PC (hazard unit).
- redirect_valid  in  1  EX reports a mispredict or unpredicted jump; take redirect_target.
- redirect_target  in  XLEN  correct next PC.
- upd_valid  in  1  EX resolved a branch/jump this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  XLEN  resolved taken target.
- pc  out  XLEN  current fetch PC (registered).
- pred_taken  out  1  fetch-stage prediction for pc.
- pred_target  out  XLEN  predicted target (valid when pred_taken).
- flush  out  1  flush IF/ID and ID/EX; combinational, equals redirect_valid.

Behaviour:
- Reset (rst=1 at clock edge):
  - pc <= RESET_VECTOR.
  - All BTB valid bits cleared.
  - All counters set to 2'b01 (weakly not-taken).
  - Reset asserted mid-operation overrides every other input in that cycle, including upd_valid; no BTB write occurs.
  - Combinational outputs after reset: pred_taken=0; flush follows redirect_valid.
- Lookup (combinational on pc):
  - idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
  - hit = valid[idx] && tag_mem[idx]==tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = target_mem[idx]; drive 0 when not hit.
- Next-PC priority (registered, one-cycle latency), highest first:
  1. rst
  2. redirect_valid -> redirect_target (redirect overrides stall)
  3. stall -> hold pc
  4. pred_taken -> pred_target
  5. otherwise pc+4
- pc+4 wraps modulo 2^XLEN (all-ones-minus-3 + 4 = 0); no carry out.
- pc[1:0] is never forced; misaligned targets are passed through unchanged.
- BTB update on upd_valid, using idx/tag computed from upd_pc:
  - Tag hit:
    - counter saturating: taken -> min(ctr+1, 3); not-taken -> max(ctr-1, 0).
    - If taken, target_mem <= upd_target.
  - Tag miss, taken: allocate; valid=1, tag written, target=upd_target, ctr=2'b10 (weakly taken). Replaces any previous occupant.
  - Tag miss, not taken: no change.
- Updates are independent of stall and redirect_valid; they are applied even while stalling or flushing.
- Same-cycle lookup and update of the same index: lookup sees the pre-update contents; the new value is visible on the next cycle (no bypass).
- Storage is flops, not RAM: no read latency, and reset clears the valid bits.

Decomposition:
- Package pc_pkg holds:
  - Counter constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - typedef ctr_t (logic [1:0]).
  - PC increment constant PC_STEP=4.
- Sub-module pc_btb(#XLEN, BTB_ENTRIES) contains:
  - Valid/tag/target/counter arrays.
  - The combinational lookup port.
  - The synchronous update port.
- pc_predict_unit instantiates pc_btb and holds the PC register and next-PC priority mux.

Test Plan:
- Reset then 3 free-running cycles, no updates -> pc = 0, 4, 8, 0xC; pred_taken=0; flush=0.
- Branch allocate:
  - Stimulus: upd_valid, upd_pc=0x10, upd_taken=1, upd_target=0x40, while pc runs from 0.
  - Response: when pc reaches 0x10, pred_taken=1 and pred_target=0x40; next pc=0x40.
- Counter training:
  - Stimulus: two not-taken updates at 0x10 after allocation.
  - Response: ctr 10->01->00; pred_taken=0 at 0x10 and next pc=0x14.
  - A further not-taken update keeps ctr at 00 (saturates).
- Stall vs redirect:
  - Stall=1 for 2 cycles at pc=0x8 -> pc holds 0x8.
  - Stall=1 and redirect_valid=1 with target 0x100 in the same cycle -> flush=1 that cycle; next pc=0x100.
- Boundary cases:
  - RESET_VECTOR=0xFFFFFFF8 -> pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - rst asserted together with upd_valid (taken) -> BTB stays empty and pc = RESET_VECTOR.
- Aliasing (BTB_ENTRIES=16):
  - Allocate 0x10, then allocate 0x50 (same idx=4, different tag).
  - Response: lookup at 0x10 misses (pred_taken=0); lookup at 0x50 hits.
